link_tx_sched: RTL and testbench

//  USB link-layer transmit sequencer, the initiating/responding counterpart of the rx-side link control.

---
 rtl/link_pkg.sv | 12 +
 rtl/link_tx_sched_if.sv | 18 +
 rtl/link_tx_timer.sv | 29 ++
 rtl/link_tx_sched.sv | 133 +++++++++++++
 tb/tb_link_tx_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// link_pkg: PIDs, error codes and sequencer states shared by the USB link tx path
package link_pkg;
    localparam logic [3:0] TOK_IN  = 4'b1001;
    localparam logic [3:0] TOK_OUT = 4'b0001;
    localparam logic [3:0] DATA0   = 4'b0011;
    localparam logic [3:0] DATA1   = 4'b1011;
    localparam logic [3:0] ACK     = 4'b0010;
    localparam logic [3:0] NAK     = 4'b1010;
    localparam logic [3:0] STALL   = 4'b1110;
    typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_NAK = 2'd1, ERR_STALL = 2'd2, ERR_TMO = 2'd3} err_t;
    typedef enum logic [2:0] {IDLE, TOKEN, TURN, DATA_TX, HS_TX, WAIT_HS, WAIT_DATA, DONE} st_t;
endpackage

// File: rtl/link_tx_sched_if.sv
// link_tx_sched_if: request, receive-event and transmitter handshake bundle for link_tx_sched
interface link_tx_sched_if;
    logic       req_valid, req_ready, req_dir;
    logic       rx_pid_en, rx_lt_eop_en, rx_crc_err;
    logic [3:0] rx_pid;
    logic       tok_start, tok_done, dat_start, dat_done, hs_start, hs_done;
    logic [3:0] tok_pid, dat_pid, hs_pid;
    logic       tx_oe, xfer_done;
    logic [1:0] err_code;
    modport master (
        input  req_valid, req_dir, rx_pid_en, rx_pid, rx_lt_eop_en, rx_crc_err, tok_done, dat_done, hs_done,
        output req_ready, tok_start, tok_pid, dat_start, dat_pid, hs_start, hs_pid, tx_oe, xfer_done, err_code
    );
    modport slave (
        output req_valid, req_dir, rx_pid_en, rx_pid, rx_lt_eop_en, rx_crc_err, tok_done, dat_done, hs_done,
        input  req_ready, tok_start, tok_pid, dat_start, dat_pid, hs_start, hs_pid, tx_oe, xfer_done, err_code
    );
endinterface

// File: rtl/link_tx_timer.sv
// link_tx_timer: turnaround and wait-state timeout counters, each cleared whenever its state is left
module link_tx_timer #(
    parameter int TO_W  = 16,
    parameter int DLY_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_turn,
    input  logic             in_wait,
    input  logic [TO_W-1:0]  time_threshold,
    input  logic [DLY_W-1:0] delay_threshold,
    output logic             turn_done,
    output logic             timeout
);
    logic [DLY_W-1:0] dcnt;
    logic [TO_W-1:0]  tcnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
            tcnt <= '0;
        end else begin
            dcnt <= in_turn ? dcnt + DLY_W'(1) : '0;
            tcnt <= in_wait ? tcnt + TO_W'(1) : '0;
        end
    end
    assign turn_done = in_turn && dcnt == delay_threshold;
    // the wait cycle in which tcnt+1 reaches the threshold is the last one spent waiting
    assign timeout = in_wait && ({1'b0, tcnt} + (TO_W + 1)'(1) == {1'b0, time_threshold});
endmodule

// File: rtl/link_tx_sched.sv
// link_tx_sched: USB link-layer tx sequencer for master and slave roles
// Define LINK_TX_RETRY_EN to let a master re-issue its token after NAK/timeout up to MAX_RETRY times.
module link_tx_sched
    import link_pkg::*;
#(
    parameter int TO_W      = 16,
    parameter int DLY_W     = 6,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ms,
    input  logic [TO_W-1:0]  time_threshold,
    input  logic [DLY_W-1:0] delay_threshold,
    input  logic             slv_data_avail,
    link_tx_sched_if.master  bus
);
    localparam int RW = $clog2(MAX_RETRY + 2);
`ifdef LINK_TX_RETRY_EN
    localparam int RETRY_LIM = MAX_RETRY;
`else
    localparam int RETRY_LIM = 0;
`endif
    st_t state, state_n;
    err_t err, err_n;
    logic dir, hs_nak, nak_n, flip, retry_inc, retry_ok, turn_done, timeout;
    logic tgl_in, tgl_out;
    logic [RW-1:0] retry;
    logic rx_ack, rx_nak, rx_stall;
    assign rx_ack   = bus.rx_pid_en && bus.rx_pid == ACK;
    assign rx_nak   = bus.rx_pid_en && bus.rx_pid == NAK;
    assign rx_stall = bus.rx_pid_en && bus.rx_pid == STALL;
    assign retry_ok = ms && int'(retry) < RETRY_LIM;
    link_tx_timer #(.TO_W(TO_W), .DLY_W(DLY_W)) timer (
        .clk(clk),
        .rst(rst),
        .in_turn(state == TURN),
        .in_wait(state == WAIT_HS || state == WAIT_DATA),
        .time_threshold(time_threshold),
        .delay_threshold(delay_threshold),
        .turn_done(turn_done),
        .timeout(timeout)
    );
    always_comb begin
        state_n   = state;
        err_n     = err;
        nak_n     = hs_nak;
        flip      = 1'b0;
        retry_inc = 1'b0;
        case (state)
            IDLE: begin
                nak_n = 1'b0;
                if (ms && bus.req_valid) state_n = TOKEN;
                else if (!ms && bus.rx_pid_en && bus.rx_pid == TOK_IN) state_n = TURN;
                else if (!ms && bus.rx_pid_en && bus.rx_pid == TOK_OUT) state_n = WAIT_DATA;
            end
            TOKEN: if (bus.tok_done) state_n = dir ? WAIT_DATA : DATA_TX;
            TURN: if (turn_done) begin
                state_n = (!ms && dir && slv_data_avail) ? DATA_TX : HS_TX;
                nak_n   = hs_nak || (!ms && dir && !slv_data_avail);
            end
            DATA_TX: if (bus.dat_done) state_n = WAIT_HS;
            HS_TX: if (bus.hs_done) begin
                state_n = DONE;
                err_n   = hs_nak ? ERR_NAK : ERR_OK;
                flip    = !hs_nak;
            end
            WAIT_HS: begin
                if (rx_ack) begin
                    state_n = DONE;
                    err_n   = ERR_OK;
                    flip    = 1'b1;
                end else if (rx_stall) begin
                    state_n = DONE;
                    err_n   = ERR_STALL;
                end else if (rx_nak || timeout) begin
                    state_n   = retry_ok ? TOKEN : DONE;
                    err_n     = rx_nak ? ERR_NAK : ERR_TMO;
                    retry_inc = retry_ok;
                end
            end
            WAIT_DATA: begin
                // a corrupt IN payload gets no handshake from a master; a slave answers it with NAK
                if (bus.rx_lt_eop_en) begin
                    state_n = (ms && bus.rx_crc_err) ? DONE : TURN;
                    err_n   = (ms && bus.rx_crc_err) ? ERR_TMO : err;
                    nak_n   = bus.rx_crc_err;
                end else if (timeout) begin
                    state_n   = retry_ok ? TOKEN : DONE;
                    err_n     = ERR_TMO;
                    retry_inc = retry_ok;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            err           <= ERR_OK;
            hs_nak        <= 1'b0;
            dir           <= 1'b0;
            tgl_in        <= 1'b0;
            tgl_out       <= 1'b0;
            retry         <= '0;
            bus.tok_start <= 1'b0;
            bus.dat_start <= 1'b0;
            bus.hs_start  <= 1'b0;
            bus.xfer_done <= 1'b0;
        end else begin
            err           <= err_n;
            hs_nak        <= nak_n;
            if (state == IDLE) dir <= ms ? bus.req_dir : bus.rx_pid == TOK_IN;
            tgl_in        <= tgl_in ^ (flip && dir);
            tgl_out       <= tgl_out ^ (flip && !dir);
            retry         <= (state == IDLE) ? '0 : retry + RW'(retry_inc);
            bus.tok_start <= state_n == TOKEN && state != TOKEN;
            bus.dat_start <= state_n == DATA_TX && state != DATA_TX;
            bus.hs_start  <= state_n == HS_TX && state != HS_TX;
            bus.xfer_done <= state_n == DONE;
        end
    end
    assign bus.req_ready = ms && state == IDLE;
    assign bus.tok_pid   = dir ? TOK_IN : TOK_OUT;
    assign bus.dat_pid   = (dir ? tgl_in : tgl_out) ? DATA1 : DATA0;
    assign bus.hs_pid    = hs_nak ? NAK : ACK;
    assign bus.tx_oe     = state inside {TOKEN, DATA_TX, HS_TX};
    assign bus.err_code  = err;
endmodule

// File: tb/tb_link_tx_sched.sv
// tb_link_tx_sched: directed master/slave transactions for link_tx_sched with hand-computed expectations
module tb_link_tx_sched;
    import link_pkg::*;
`ifdef LINK_TX_RETRY_EN
    localparam int EXP_TOK = 4;
`else
    localparam int EXP_TOK = 1;
`endif
    logic        clk = 1'b0, rst = 1'b1, ms = 1'b1, slv_data_avail = 1'b0;
    logic [15:0] time_threshold = 16'd100;
    logic [5:0]  delay_threshold = 6'd2;
    int errors = 0, checks = 0, n, toks;
    link_tx_sched_if bus();
    link_tx_sched dut (
        .clk(clk),
        .rst(rst),
        .ms(ms),
        .time_threshold(time_threshold),
        .delay_threshold(delay_threshold),
        .slv_data_avail(slv_data_avail),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic sig(input int s);
        return s == 0 ? bus.tok_start : s == 1 ? bus.dat_start : s == 2 ? bus.hs_start : bus.xfer_done;
    endfunction
    task automatic wait_for(input int s, input int lim, output int cnt);
        cnt = -1;
        for (int i = 0; i <= lim; i++) begin
            if (sig(s)) begin
                cnt = i;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $error("FAIL wait_%0d: no pulse within %0d cycles", s, lim);
    endtask
    task automatic pulse(input int s);
        if (s == 0) bus.tok_done = 1'b1;
        else if (s == 1) bus.dat_done = 1'b1;
        else if (s == 2) bus.hs_done = 1'b1;
        else bus.rx_lt_eop_en = 1'b1;
        @(negedge clk);
        bus.tok_done = 1'b0;
        bus.dat_done = 1'b0;
        bus.hs_done = 1'b0;
        bus.rx_lt_eop_en = 1'b0;
    endtask
    task automatic rx(input logic [3:0] p);
        bus.rx_pid_en = 1'b1;
        bus.rx_pid = p;
        @(negedge clk);
        bus.rx_pid_en = 1'b0;
    endtask
    task automatic req(input logic d);
        bus.req_valid = 1'b1;
        bus.req_dir = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask
    initial begin
        bus.req_valid = 0; bus.req_dir = 0; bus.rx_pid_en = 0; bus.rx_pid = 0;
        bus.rx_lt_eop_en = 0; bus.rx_crc_err = 0; bus.tok_done = 0; bus.dat_done = 0; bus.hs_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_oe", int'(bus.tx_oe), 0);
        chk("rst_done", int'(bus.xfer_done), 0);
        chk("rst_err", int'(bus.err_code), 0);
        chk("rst_starts", int'({bus.tok_start, bus.dat_start, bus.hs_start}), 0);
        rst = 1'b0;
        ms = 1'b0;
        #1 chk("slave_ready", int'(bus.req_ready), 0);
        ms = 1'b1;
        @(negedge clk);
        // master OUT acknowledged
        req(1'b0);
        chk("a_tok", int'(bus.tok_start), 1);
        chk("a_tok_pid", int'(bus.tok_pid), 'h1);
        chk("a_oe", int'(bus.tx_oe), 1);
        chk("a_busy", int'(bus.req_ready), 0);
        pulse(0);
        chk("a_dat", int'(bus.dat_start), 1);
        chk("a_dat_pid", int'(bus.dat_pid), 'h3);
        pulse(1);
        chk("a_wait_oe", int'(bus.tx_oe), 0);
        rx(ACK);
        chk("a_done", int'(bus.xfer_done), 1);
        chk("a_err", int'(bus.err_code), 0);
        @(negedge clk);
        chk("a_one_cycle", int'(bus.xfer_done), 0);
        chk("a_idle", int'(bus.req_ready), 1);
        // master OUT with no handshake times out
        time_threshold = 16'd20;
        req(1'b0);
        pulse(0);
        chk("b_dat_pid", int'(bus.dat_pid), 'hb);
        pulse(1);
        wait_for(3, 40, n);
        chk("b_tmo_cycles", n, 20);
        chk("b_err", int'(bus.err_code), 3);
        @(negedge clk);
        // master OUT NAKed on every attempt
        time_threshold = 16'd100;
        req(1'b0);
        toks = 0;
        for (int a = 0; a < 6 && !bus.xfer_done; a++) begin
            if (bus.tok_start) toks++;
            pulse(0);
            pulse(1);
            rx(NAK);
        end
        chk("c_tokens", toks, EXP_TOK);
        chk("c_done", int'(bus.xfer_done), 1);
        chk("c_err", int'(bus.err_code), 1);
        @(negedge clk);
        // master OUT: foreign PID ignored, then STALL
        req(1'b0);
        pulse(0);
        chk("d_dat_pid", int'(bus.dat_pid), 'hb);
        pulse(1);
        rx(DATA1);
        chk("d_ignored", int'(bus.xfer_done), 0);
        rx(STALL);
        chk("d_done", int'(bus.xfer_done), 1);
        chk("d_err", int'(bus.err_code), 2);
        @(negedge clk);
        // reset in the middle of DATA_TX
        req(1'b0);
        pulse(0);
        chk("h_dat_pid", int'(bus.dat_pid), 'hb);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("h_abort_oe", int'(bus.tx_oe), 0);
        chk("h_abort_ready", int'(bus.req_ready), 1);
        pulse(1);
        chk("h_stray_done", int'({bus.xfer_done, bus.dat_start, bus.tok_start}), 0);
        // ACK in the very cycle the timeout would fire
        time_threshold = 16'd20;
        req(1'b0);
        pulse(0);
        chk("e_dat_pid_cleared", int'(bus.dat_pid), 'h3);
        pulse(1);
        repeat (19) @(negedge clk);
        rx(ACK);
        chk("e_done", int'(bus.xfer_done), 1);
        chk("e_event_wins", int'(bus.err_code), 0);
        @(negedge clk);
        // master IN
        time_threshold = 16'd100;
        req(1'b1);
        chk("f_tok_pid", int'(bus.tok_pid), 'h9);
        pulse(0);
        chk("f_wait_oe", int'(bus.tx_oe), 0);
        chk("f_no_data", int'(bus.dat_start), 0);
        pulse(3);
        wait_for(2, 10, n);
        chk("f_turn", n, 3);
        chk("f_hs_pid", int'(bus.hs_pid), 'h2);
        chk("f_hs_oe", int'(bus.tx_oe), 1);
        pulse(2);
        chk("f_done", int'(bus.xfer_done), 1);
        chk("f_err", int'(bus.err_code), 0);
        @(negedge clk);
        // master IN with CRC error
        req(1'b1);
        pulse(0);
        bus.rx_crc_err = 1'b1;
        pulse(3);
        bus.rx_crc_err = 1'b0;
        chk("g_done", int'(bus.xfer_done), 1);
        chk("g_err", int'(bus.err_code), 3);
        chk("g_no_hs", int'(bus.hs_start), 0);
        @(negedge clk);
        chk("g_no_hs_later", int'(bus.hs_start), 0);
        // slave role from a clean toggle state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ms = 1'b0;
        #1 chk("s_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rx(TOK_IN);
        wait_for(2, 10, n);
        chk("s1_turn", n, 3);
        chk("s1_hs_pid", int'(bus.hs_pid), 'ha);
        chk("s1_oe", int'(bus.tx_oe), 1);
        pulse(2);
        chk("s1_done", int'(bus.xfer_done), 1);
        @(negedge clk);
        delay_threshold = 6'd0;
        slv_data_avail = 1'b1;
        rx(TOK_IN);
        wait_for(1, 10, n);
        chk("s2_turn0", n, 1);
        chk("s2_dat_pid", int'(bus.dat_pid), 'h3);
        pulse(1);
        rx(ACK);
        chk("s2_done", int'(bus.xfer_done), 1);
        chk("s2_err", int'(bus.err_code), 0);
        @(negedge clk);
        delay_threshold = 6'd2;
        rx(TOK_IN);
        wait_for(1, 10, n);
        chk("s3_turn", n, 3);
        chk("s3_dat_pid", int'(bus.dat_pid), 'hb);
        pulse(1);
        rx(NAK);
        chk("s3_done", int'(bus.xfer_done), 1);
        chk("s3_err", int'(bus.err_code), 1);
        @(negedge clk);
        rx(TOK_OUT);
        chk("s4_wait_oe", int'(bus.tx_oe), 0);
        bus.rx_crc_err = 1'b1;
        pulse(3);
        bus.rx_crc_err = 1'b0;
        wait_for(2, 10, n);
        chk("s4_turn", n, 3);
        chk("s4_hs_pid", int'(bus.hs_pid), 'ha);
        pulse(2);
        chk("s4_done", int'(bus.xfer_done), 1);
        @(negedge clk);
        rx(TOK_OUT);
        pulse(3);
        wait_for(2, 10, n);
        chk("s5_hs_pid", int'(bus.hs_pid), 'h2);
        pulse(2);
        chk("s5_err", int'(bus.err_code), 0);
        @(negedge clk);
        // OUT toggle moved once: by the ACKed slave OUT, not the CRC-failed one
        ms = 1'b1;
        time_threshold = 16'd5;
        @(negedge clk);
        req(1'b0);
        pulse(0);
        chk("m_out_toggle", int'(bus.dat_pid), 'hb);
        pulse(1);
        wait_for(3, 20, n);
        chk("m_tmo_cycles", n, 5);
        chk("m_err", int'(bus.err_code), 3);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
